// File: rtl/ctrl_decode_seq_if.sv
// Decode/sequencer bus between the IF/ID side and the ID-stage control unit.
// The illegal flag exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface ctrl_decode_seq_if #(
  parameter int OPCODE_W = 6,
  parameter int EXEC_W   = 4,
  parameter int SEL_W    = 2
);
  logic [OPCODE_W-1:0] opcode;
  logic                hazard_stall;
  logic                flush;
  logic                freeze;
  logic [SEL_W-1:0]    swp_sel;
  logic [EXEC_W-1:0]   exec_cmd;
  logic                mem_r_en;
  logic                mem_w_en;
  logic                wb_en;
  logic                is_imm;
  logic [1:0]          branch_type;
  logic                single_src;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic                illegal;
`endif

  modport master (
    output opcode, hazard_stall, flush,
    input  freeze, swp_sel, exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm,
           branch_type, single_src
`ifdef CTRL_ILLEGAL_TRAP_EN
    , input illegal
`endif
  );

  modport slave (
    input  opcode, hazard_stall, flush,
    output freeze, swp_sel, exec_cmd, mem_r_en, mem_w_en, wb_en, is_imm,
           branch_type, single_src
`ifdef CTRL_ILLEGAL_TRAP_EN
    , output illegal
`endif
  );
endinterface

// File: rtl/ctrl_decode_seq.sv
// Registered ID-stage control decoder with a multi-step SWP micro-op sequencer.
// Optional illegal-opcode pulse output enabled by defining CTRL_ILLEGAL_TRAP_EN.
module ctrl_decode_seq #(
  parameter int                OPCODE_W     = 6,
  parameter int                EXEC_W       = 4,
  parameter logic [5:0]        SWP_OPCODE   = 6'h3F,
  parameter int                SWP_STEPS    = 2,
  parameter logic [EXEC_W-1:0] SWP_CMD_BASE = EXEC_W'(4'hC)
) (
  input  logic            clk,
  input  logic            rst,
  ctrl_decode_seq_if.slave bus
);
  localparam int SEL_W = $clog2(SWP_STEPS + 1);

  typedef enum logic { S_DECODE, S_SEQ } state_t;

  typedef struct packed {
    logic [EXEC_W-1:0] exec;
    logic              rd;
    logic              wr;
    logic              wb;
    logic              imm;
    logic [1:0]        bt;
    logic              ss;
  } dec_t;

  typedef struct packed {
    logic              freeze;
    logic [SEL_W-1:0]  sel;
    dec_t              cmd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic              illegal;
`endif
  } out_t;

  function automatic dec_t decode_op(input logic [OPCODE_W-1:0] op);
    dec_t d;
    d = '0;
    if ((op >> 6) == '0) begin
      case (op[5:0])
        6'h01: d.wb = 1'b1;
        6'h03: begin d.exec = EXEC_W'(4'h2); d.wb = 1'b1; end
        6'h05: begin d.exec = EXEC_W'(4'h4); d.wb = 1'b1; end
        6'h06: begin d.exec = EXEC_W'(4'h5); d.wb = 1'b1; end
        6'h07: begin d.exec = EXEC_W'(4'h6); d.wb = 1'b1; end
        6'h08: begin d.exec = EXEC_W'(4'h7); d.wb = 1'b1; end
        6'h09: begin d.exec = EXEC_W'(4'h8); d.wb = 1'b1; end
        6'h0A: begin d.exec = EXEC_W'(4'h8); d.wb = 1'b1; end
        6'h0B: begin d.exec = EXEC_W'(4'h9); d.wb = 1'b1; end
        6'h0C: begin d.exec = EXEC_W'(4'hA); d.wb = 1'b1; end
        6'h20: begin d.wb = 1'b1; d.imm = 1'b1; d.ss = 1'b1; end
        6'h21: begin d.exec = EXEC_W'(4'h2); d.wb = 1'b1; d.imm = 1'b1; d.ss = 1'b1; end
        6'h24: begin d.rd = 1'b1; d.wb = 1'b1; d.imm = 1'b1; d.ss = 1'b1; end
        6'h25: begin d.wr = 1'b1; d.imm = 1'b1; end
        6'h28: begin d.imm = 1'b1; d.ss = 1'b1; d.bt = 2'b01; end
        6'h29: begin d.imm = 1'b1; d.bt = 2'b10; end
        6'h2A: begin d.imm = 1'b1; d.ss = 1'b1; d.bt = 2'b11; end
        default: d = '0;
      endcase
    end
    return d;
  endfunction

  state_t           state_p0, state_nxt;
  logic [SEL_W-1:0] step_p0, step_nxt;
  out_t             out_p0, out_nxt;
  dec_t             dec;

  always_comb begin
    dec       = decode_op(bus.opcode);
    state_nxt = state_p0;
    step_nxt  = step_p0;
    out_nxt   = '0;
    if (bus.flush) begin
      state_nxt = S_DECODE;
      step_nxt  = '0;
    end else if (bus.hazard_stall) begin
      // Bubble; fetch stays frozen only while a swap is mid-sequence.
      out_nxt.freeze = (state_p0 == S_SEQ);
    end else if (state_p0 == S_SEQ) begin
      out_nxt.cmd.wb   = 1'b1;
      out_nxt.cmd.exec = SWP_CMD_BASE + EXEC_W'(step_p0);
      out_nxt.sel      = step_p0 + SEL_W'(1);
      if (step_p0 == SEL_W'(SWP_STEPS - 1)) begin
        state_nxt = S_DECODE;
        step_nxt  = '0;
      end else begin
        out_nxt.freeze = 1'b1;
        step_nxt       = step_p0 + SEL_W'(1);
      end
    end else if (bus.opcode == OPCODE_W'(SWP_OPCODE)) begin
      out_nxt.cmd.wb   = 1'b1;
      out_nxt.cmd.exec = SWP_CMD_BASE;
      out_nxt.sel      = SEL_W'(1);
      if (SWP_STEPS > 1) begin
        out_nxt.freeze = 1'b1;
        state_nxt      = S_SEQ;
        step_nxt       = SEL_W'(1);
      end
    end else begin
      out_nxt.cmd = dec;
`ifdef CTRL_ILLEGAL_TRAP_EN
      // Every legal non-NOP opcode sets at least one bundle bit.
      out_nxt.illegal = (dec == '0) && (bus.opcode != '0);
`endif
    end
  end

  // ---- ID -> ID/EX register boundary ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= S_DECODE;
      step_p0  <= '0;
      out_p0   <= '0;
    end else begin
      state_p0 <= state_nxt;
      step_p0  <= step_nxt;
      out_p0   <= out_nxt;
    end
  end

  assign bus.freeze      = out_p0.freeze;
  assign bus.swp_sel     = out_p0.sel;
  assign bus.exec_cmd    = out_p0.cmd.exec;
  assign bus.mem_r_en    = out_p0.cmd.rd;
  assign bus.mem_w_en    = out_p0.cmd.wr;
  assign bus.wb_en       = out_p0.cmd.wb;
  assign bus.is_imm      = out_p0.cmd.imm;
  assign bus.branch_type = out_p0.cmd.bt;
  assign bus.single_src  = out_p0.cmd.ss;
`ifdef CTRL_ILLEGAL_TRAP_EN
  assign bus.illegal     = out_p0.illegal;
`endif
endmodule
